key_bcd_counter_display: RTL and testbench
==========================================

// Module: key_bcd_counter_display
// PURPOSE
//  Board-level BCD up/down counter driven by the two push buttons. KEY presses are synchronised,
//  debounced and edge-detected; SW selects load/saturate modes and supplies load data. The count
//  is shown in decimal on HEX0..HEX5 and mirrored on LEDR. Parametrised successor of the
//  lab1 SW/KEY/LEDR/HEX top, adding clocked state, debouncing and variable digit count.
// PARAMETERS
//  NUM_DIGITS       4       enabled BCD digits, 1..6 (HEX0 = least significant digit)
//  DEBOUNCE_CYCLES  500000  consecutive stable synchronised cycles to accept a key change, >=1
// PORTS
//  CLOCK_50  in   1  system clock, all logic on rising edge
//  RESET     in   1  synchronous, active-high reset
//  KEY       in   2  push buttons, active-low (KEY[0] = up/load, KEY[1] = down)
//  SW        in  10  SW[7:0] load data (2 BCD nibbles), SW[8] saturate mode, SW[9] load mode
//  LEDR      out 10  LEDR[7:0] = digits 1:0 BCD, LEDR[8] = any key held (debounced), LEDR[9] = wrap flag
//  HEX0..HEX5 out 8 each; seven-segment, active-low, bit7 = DP (always 1), bits 6..0 = g..a
// BEHAVIOUR
//  Reset: count = 0, wrap flag = 0, debounce counters = 0, debounced keys = 2'b11 (released).
//   Outputs after reset: LEDR = 10'h000; enabled HEXn = 8'hC0 ('0'); disabled HEXn = 8'hFF.
//  Input path per key: 2-flop synchroniser -> filter counter (cleared when sync == debounced,
//   else increments; on reaching DEBOUNCE_CYCLES debounced <= sync) -> press event on debounced 1->0.
//  Latency: raw KEY held low continuously -> count register changes on the DEBOUNCE_CYCLES+3rd
//   rising edge after the first edge sampling KEY low. Glitch shorter than DEBOUNCE_CYCLES: no event.
//   Release produces no event. One press = exactly one event regardless of hold time.
//  Event handling (single cycle, priority order):
//   - both press events same cycle: no count change, wrap flag unchanged.
//   - KEY[0] event, SW[9]=1: load digit1 = SW[7:4], digit0 = SW[3:0], higher digits = 0;
//     nibble >9 loads 9; if NUM_DIGITS=1 only digit0 loads; wrap flag cleared.
//   - KEY[0] event, SW[9]=0: increment BCD with decimal carry. At max (all enabled digits 9):
//     SW[8]=0 -> wrap to 0 and set wrap flag; SW[8]=1 -> hold at max, flag unchanged.
//   - KEY[1] event (SW[9] ignored): decrement BCD with borrow. At 0:
//     SW[8]=0 -> wrap to max and set wrap flag; SW[8]=1 -> hold at 0.
//  Wrap flag is sticky; cleared only by RESET or a load.
//  LEDR, HEX are combinational decodes of registered state (visible in the same cycle as update).
//   Digits 0-9 decode: C0 F9 A4 B0 99 92 82 F8 80 90. HEXn for n >= NUM_DIGITS = 8'hFF always.
//  SW sampled directly in the event cycle (no synchroniser; SW treated as quasi-static).
//  RESET mid-debounce discards partial filter state. A key held through reset release is treated
//   as a fresh press: one event at DEBOUNCE_CYCLES+3 edges after reset deasserts.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: enabled digits above the most significant non-zero digit
//   show 8'hFF; HEX0 is never blanked (value 0 shows only HEX0 = 8'hC0).
//  Not defined: every enabled digit always shows its decimal value, including leading zeros.
// TESTING (bench: NUM_DIGITS=4, DEBOUNCE_CYCLES=4, both macro settings)
//  1 Reset, KEY=11, SW=0 -> LEDR=000, HEX0..3=C0, HEX4/5=FF (macro: HEX1..3=FF).
//  2 KEY[0] low 3 cycles then high -> no change; KEY[0] held 20 cycles -> count 1 exactly at
//    edge 7, HEX0=F9, LEDR[8]=1 while held; still 1 after release.
//  3 SW=9'h0_99 (SW[9]=1 -> 10'h299) + KEY[0] press -> count 0099, HEX1=HEX0=90; SW=10'h2FA
//    load -> 0099 (nibbles clamp to 9).
//  4 Count 9999, SW[8]=0, KEY[0] press -> 0000, LEDR[9]=1; KEY[1] press -> 9999, LEDR[9]=1;
//    SW[8]=1 KEY[0] press at 9999 -> stays 9999.
//  5 KEY[0] and KEY[1] pressed in same cycle -> count unchanged; staggered by 2 cycles -> +1 then -1.
//  6 RESET asserted mid-debounce with KEY[1] held -> count 0, flag 0; KEY[1] still held ->
//    0 wraps to 9999 at edge 7 after reset release (SW[8]=0), LEDR[9]=1.

Source files
------------

// File: rtl/key_bcd_counter_display.sv
// key_bcd_counter_display
//   Board-level BCD up/down counter driven by two push buttons.
//   Each KEY goes through a 2-flop synchroniser, a debounce filter and a
//   falling-edge detector. KEY[0] counts up or loads, and KEY[1] counts down.
//   SW supplies the load data and selects the load and saturate modes.
//   The count is shown in decimal on HEX0..HEX5 and mirrored on LEDR.
//
// Parameters
//   NUM_DIGITS       enabled BCD digits, 1..6 (HEX0 = least significant)
//   DEBOUNCE_CYCLES  stable synchronised cycles needed to accept a key change
//
// Ports
//   CLOCK_50    in   system clock, rising edge
//   RESET       in   synchronous, active-high reset
//   KEY[1:0]    in   push buttons, active-low (0 = up/load, 1 = down)
//   SW[9:0]     in   [7:0] load nibbles, [8] saturate mode, [9] load mode
//   LEDR[9:0]   out  [7:0] digits 1:0, [8] any key held, [9] sticky wrap flag
//   HEX0..HEX5  out  seven-segment, active-low, bit7 = DP (always off)
//
// Configuration macro
//   LEADING_ZERO_BLANK_EN  blanks enabled digits above the most significant
//                          non-zero digit. HEX0 is never blanked.
module key_bcd_counter_display #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    deb_r;
  logic [1:0]    deb_d_r;
  logic [CW-1:0] flt_cnt_r [2];
  logic [23:0]   count_r;
  logic          wrap_r;

  logic [1:0]    press_s;
  logic [23:0]   load_val_s;
  logic [23:0]   max_val_s;
  logic [7:0]    hex_s [6];

  // Increment the enabled digits, with decimal carry. It is never called at the maximum count.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if ((i < NUM_DIGITS) && carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

  // Decrement the enabled digits, with decimal borrow. It is never called at zero.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if ((i < NUM_DIGITS) && borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          borrow      = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        borrow = 1'b0;
      end
    end
    return r;
  endfunction

  // Limit a load nibble to a legal BCD digit.
  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Seven-segment pattern, active-low, with the decimal point off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // A press is the debounced line falling from released to pressed.
  assign press_s = deb_d_r & ~deb_r;

  // Load value and all-nines value for the enabled digits.
  always_comb begin
    load_val_s      = 24'd0;
    max_val_s       = 24'd0;
    load_val_s[3:0] = clamp9(SW[3:0]);
    if (NUM_DIGITS > 1) begin
      load_val_s[7:4] = clamp9(SW[7:4]);
    end else begin
      load_val_s[7:4] = 4'd0;
    end
    for (int i = 0; i < 6; i++) begin
      if (i < NUM_DIGITS) begin
        max_val_s[4*i +: 4] = 4'd9;
      end else begin
        max_val_s[4*i +: 4] = 4'd0;
      end
    end
  end

  // Key synchroniser, debounce filters and counter state.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      // Resetting the synchroniser to the released state means a key held through reset is seen as a new press.
      sync1_r      <= 2'b11;
      sync2_r      <= 2'b11;
      deb_r        <= 2'b11;
      deb_d_r      <= 2'b11;
      flt_cnt_r[0] <= '0;
      flt_cnt_r[1] <= '0;
      count_r      <= 24'd0;
      wrap_r       <= 1'b0;
    end else begin
      sync1_r <= KEY;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;

      for (int k = 0; k < 2; k++) begin
        if (sync2_r[k] == deb_r[k]) begin
          flt_cnt_r[k] <= '0;
        end else if (flt_cnt_r[k] == CNT_LAST) begin
          // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
          deb_r[k]     <= sync2_r[k];
          flt_cnt_r[k] <= '0;
        end else begin
          flt_cnt_r[k] <= flt_cnt_r[k] + 1'b1;
        end
      end

      if (press_s == 2'b11) begin
        count_r <= count_r;
      end else if (press_s[0]) begin
        if (SW[9]) begin
          count_r <= load_val_s;
          wrap_r  <= 1'b0;
        end else if (count_r == max_val_s) begin
          if (!SW[8]) begin
            count_r <= 24'd0;
            wrap_r  <= 1'b1;
          end else begin
            count_r <= count_r;
          end
        end else begin
          count_r <= bcd_inc(count_r);
        end
      end else if (press_s[1]) begin
        if (count_r == 24'd0) begin
          if (!SW[8]) begin
            count_r <= max_val_s;
            wrap_r  <= 1'b1;
          end else begin
            count_r <= count_r;
          end
        end else begin
          count_r <= bcd_dec(count_r);
        end
      end else begin
        count_r <= count_r;
      end
    end
  end

  // LED mirror and seven-segment decode of the registered count.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic seen;
    seen = 1'b0;
`endif
    LEDR = {wrap_r, ~(&deb_r), count_r[7:0]};
    for (int i = 0; i < 6; i++) begin
      hex_s[i] = 8'hFF;
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Scan from the top digit down. A digit is shown once a non-zero digit at or above it has been seen.
    for (int i = 5; i >= 0; i--) begin
      seen = seen | (count_r[4*i +: 4] != 4'd0);
      if ((i < NUM_DIGITS) && (seen || (i == 0))) begin
        hex_s[i] = seg7(count_r[4*i +: 4]);
      end else begin
        hex_s[i] = 8'hFF;
      end
    end
`else
    for (int i = 0; i < 6; i++) begin
      if (i < NUM_DIGITS) begin
        hex_s[i] = seg7(count_r[4*i +: 4]);
      end else begin
        hex_s[i] = 8'hFF;
      end
    end
`endif
  end

  assign HEX0 = hex_s[0];
  assign HEX1 = hex_s[1];
  assign HEX2 = hex_s[2];
  assign HEX3 = hex_s[3];
  assign HEX4 = hex_s[4];
  assign HEX5 = hex_s[5];

endmodule

// File: tb/tb_key_bcd_counter_display.sv
module tb_key_bcd_counter_display;

  localparam int ND = 4;
  localparam int DC = 4;

  localparam int OP_UP   = 0;
  localparam int OP_DN   = 1;
  localparam int OP_BOTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int tests = 0;
  int fails = 0;
  int m_cnt;
  bit m_wrap;

  typedef struct {
    int         op;
    logic [9:0] sw;
    int         exp_cnt;
    bit         exp_wrap;
  } vec_t;

  vec_t vecs[18];

  key_bcd_counter_display #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50(clk), .RESET(rst), .KEY(key), .SW(sw), .LEDR(ledr),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(int d);
    logic [7:0] lut [10];
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return lut[d];
  endfunction

  // Expected HEX value worked out from the integer count.
  function automatic logic [7:0] exp_hex(int cnt, int i);
    if (i >= ND) return 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && cnt < 10 ** i) return 8'hFF;
`endif
    return seg_of((cnt / (10 ** i)) % 10);
  endfunction

  task automatic cmp(input string nm, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string nm, input int cnt, input bit wrap, input bit held);
    logic [9:0] el;
    logic [7:0] hx [6];
    el = {wrap, held, 4'((cnt / 10) % 10), 4'(cnt % 10)};
    hx = '{hex0, hex1, hex2, hex3, hex4, hex5};
    cmp({nm, " LEDR"}, ledr, el);
    for (int i = 0; i < 6; i++)
      cmp($sformatf("%s HEX%0d", nm, i), {2'b00, hx[i]}, {2'b00, exp_hex(cnt, i)});
  endtask

  // Behavioural reference model using integer arithmetic on the decimal value.
  task automatic m_apply(input int op, input logic [9:0] s);
    int hi, lo, maxv;
    maxv = 10 ** ND - 1;
    if (op == OP_BOTH) begin
    end else if (op == OP_UP) begin
      if (s[9]) begin
        hi = (s[7:4] > 9) ? 9 : int'(s[7:4]);
        lo = (s[3:0] > 9) ? 9 : int'(s[3:0]);
        m_cnt  = hi * 10 + lo;
        m_wrap = 1'b0;
      end else if (m_cnt == maxv) begin
        if (!s[8]) begin m_cnt = 0; m_wrap = 1'b1; end
      end else m_cnt = m_cnt + 1;
    end else begin
      if (m_cnt == 0) begin
        if (!s[8]) begin m_cnt = maxv; m_wrap = 1'b1; end
      end else m_cnt = m_cnt - 1;
    end
  endtask

  task automatic press(input int op);
    @(negedge clk);
    key = (op == OP_UP) ? 2'b10 : (op == OP_DN) ? 2'b01 : 2'b00;
    repeat (12) @(negedge clk);
    key = 2'b11;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    vecs = '{
      '{OP_UP,   10'h245,   45, 1'b0},
      '{OP_UP,   10'h000,   46, 1'b0},
      '{OP_DN,   10'h000,   45, 1'b0},
      '{OP_UP,   10'h209,    9, 1'b0},
      '{OP_UP,   10'h000,   10, 1'b0},
      '{OP_DN,   10'h000,    9, 1'b0},
      '{OP_UP,   10'h200,    0, 1'b0},
      '{OP_DN,   10'h100,    0, 1'b0},
      '{OP_DN,   10'h000, 9999, 1'b1},
      '{OP_UP,   10'h100, 9999, 1'b1},
      '{OP_UP,   10'h000,    0, 1'b1},
      '{OP_BOTH, 10'h000,    0, 1'b1},
      '{OP_DN,   10'h200, 9999, 1'b1},
      '{OP_UP,   10'h299,   99, 1'b0},
      '{OP_UP,   10'h2FA,   99, 1'b0},
      '{OP_UP,   10'h000,  100, 1'b0},
      '{OP_DN,   10'h000,   99, 1'b0},
      '{OP_UP,   10'h3FF,   99, 1'b0}
    };

    rst = 1'b1; key = 2'b11; sw = 10'h000;
    repeat (3) @(negedge clk);
    check_state("reset_hold", 0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset", 0, 1'b0, 1'b0);

    // A glitch shorter than the debounce window produces no event.
    @(negedge clk); key = 2'b10;
    repeat (3) @(negedge clk); key = 2'b11;
    repeat (12) @(negedge clk);
    check_state("glitch", 0, 1'b0, 1'b0);

    // Held key: the count changes exactly at edge 7.
    @(negedge clk); key = 2'b10;
    repeat (6) @(posedge clk); #1;
    check_state("lat_e6", 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_state("lat_e7", 1, 1'b0, 1'b1);
    repeat (13) @(posedge clk); #1;
    check_state("held20", 1, 1'b0, 1'b1);
    @(negedge clk); key = 2'b11;
    repeat (12) @(negedge clk);
    check_state("release", 1, 1'b0, 1'b0);
    m_cnt = 1; m_wrap = 1'b0;

    for (int i = 0; i < 18; i++) begin
      sw = vecs[i].sw;
      press(vecs[i].op);
      m_apply(vecs[i].op, vecs[i].sw);
      check_state($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_wrap, 1'b0);
      cmp($sformatf("vec%0d model", i), 10'(m_cnt), 10'(vecs[i].exp_cnt));
      m_cnt = vecs[i].exp_cnt; m_wrap = vecs[i].exp_wrap;
    end

    // Staggered presses: KEY[0] then KEY[1] two cycles later give +1 and then -1.
    sw = 10'h000;
    @(negedge clk); key = 2'b10;
    repeat (2) @(negedge clk); key = 2'b00;
    repeat (5) @(posedge clk); #1;
    check_state("stag_up", 100, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;
    check_state("stag_dn", 99, 1'b0, 1'b1);
    @(negedge clk); key = 2'b11;
    repeat (12) @(negedge clk);
    check_state("stag_rel", 99, 1'b0, 1'b0);

    // Reset during debounce, with KEY[1] still held after reset is released.
    @(negedge clk); key = 2'b01;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_state("rst_mid", 0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    check_state("rst_e6", 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_state("rst_e7", 9999, 1'b1, 1'b1);
    @(negedge clk); key = 2'b11;
    repeat (12) @(negedge clk);
    check_state("rst_rel", 9999, 1'b1, 1'b0);
    m_cnt = 9999; m_wrap = 1'b1;

    // Random operations checked against the reference model.
    for (int n = 0; n < 150; n++) begin
      int         op;
      logic [9:0] s;
      op = $urandom_range(0, 2);
      s  = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) s[9] = 1'b0;
      sw = s;
      press(op);
      m_apply(op, s);
      check_state($sformatf("rand%0d", n), m_cnt, m_wrap, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
